// File: rtl/rst_release_seq.sv
// Reset release sequencer: synchronises RESETN deassertion, then releases
// NUM_DOMAINS resets in order with a delay and ready handshake between stages.
// Optional ready timeout is enabled by defining RST_SEQ_TIMEOUT_EN.
module rst_release_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DLY_W       = 8,
  parameter int TIMEOUT_CYC = 255,
  localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   sw_rst_req,
  input  logic [DLY_W-1:0]       stage_dly,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic [IDX_W-1:0]       cur_dom,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   timeout_err
);

  // state      | meaning
  // HOLD       | all domains in reset, waiting for rst_sync and no sw request
  // DELAY      | counting down the inter-stage delay before releasing idx
  // WAIT_READY | domain idx released, waiting for dom_ready[idx]
  // DONE       | every domain released
  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;
  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [DLY_W-1:0]       cnt;
  logic [DLY_W-1:0]       dly_load;
  logic                   ready_sel;
  logic                   timeout_hit;
  logic                   advance;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // A delay of zero is treated as one cycle in DELAY.
  assign dly_load  = (stage_dly == '0) ? '0 : stage_dly - 1'b1;
  assign ready_sel = dom_ready[idx];
  assign advance   = ready_sel | timeout_hit;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TO_LAST);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wait_cnt <= '0;
    end else if (sw_rst_req || (state != ST_WAIT) || advance) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      timeout_err <= 1'b0;
    end else if (sw_rst_req) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit && !ready_sel) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= ST_HOLD;
      idx       <= '0;
      cnt       <= '0;
      dom_rst_n <= '0;
    end else if (sw_rst_req) begin
      state     <= ST_HOLD;
      idx       <= '0;
      cnt       <= '0;
      dom_rst_n <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          idx       <= '0;
          dom_rst_n <= '0;
          if (rst_sync) begin
            cnt   <= dly_load;
            state <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (cnt == '0) begin
            dom_rst_n[idx] <= 1'b1;
            state          <= ST_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (advance) begin
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              cnt   <= dly_load;
              state <= ST_DELAY;
            end
          end
        end
        ST_DONE: begin
          dom_rst_n <= '1;
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  assign cur_dom  = idx;
  assign busy     = (state != ST_DONE);
  assign seq_done = (state == ST_DONE);

endmodule
